// File: rtl/td4_pkg.sv
// ============================================================================
// Module : td4_pkg
// Brief  : Shared types and constants for the TD4 control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package td4_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_IN   = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

endpackage

`default_nettype wire

// File: rtl/td4_ctrl_if.sv
// ============================================================================
// Module : td4_ctrl_if
// Brief  : Control/datapath bus between the TD4 controller and its datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface td4_ctrl_if #(
  parameter int DW = 4
);
  logic [DW+3:0] instr;
  logic          c_alu;
  logic [3:0]    ld;
  logic [1:0]    sel;
  logic [DW-1:0] imm;
  logic          pc_inc;

  modport master (
    input  instr, c_alu,
    output ld, sel, imm, pc_inc
  );

  modport slave (
    output instr, c_alu,
    input  ld, sel, imm, pc_inc
  );
endinterface

`default_nettype wire

// File: rtl/td4_decode.sv
// ============================================================================
// Module : td4_decode
// Brief  : Combinational instruction decoder (opcode/imm/carry -> controls).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module td4_decode
  import td4_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_imm,
  input  logic          i_carry,
  output logic [3:0]    o_ld,
  output logic [1:0]    o_sel,
  output logic [DW-1:0] o_imm,
  output logic          o_pc_inc
);

  always_comb begin
    o_ld     = '0;
    o_sel    = SEL_A;
    o_imm    = i_imm;
    o_pc_inc = 1'b1;
    case (i_op)
      OP_ADD_A:  o_ld[LD_A] = 1'b1;
      OP_ADD_B:  begin o_sel = SEL_B;    o_ld[LD_B] = 1'b1; end
      OP_MOV_A:  begin o_sel = SEL_ZERO; o_ld[LD_A] = 1'b1; end
      OP_MOV_B:  begin o_sel = SEL_ZERO; o_ld[LD_B] = 1'b1; end
      OP_MOV_AB: begin o_sel = SEL_B;  o_imm = '0; o_ld[LD_A] = 1'b1; end
      OP_MOV_BA: begin o_sel = SEL_A;  o_imm = '0; o_ld[LD_B] = 1'b1; end
      OP_IN_A:   begin o_sel = SEL_IN; o_imm = '0; o_ld[LD_A] = 1'b1; end
      OP_IN_B:   begin o_sel = SEL_IN; o_imm = '0; o_ld[LD_B] = 1'b1; end
      OP_OUT_B:  begin o_sel = SEL_B;  o_imm = '0; o_ld[LD_OUT] = 1'b1; end
      OP_OUT_I:  begin o_sel = SEL_ZERO; o_ld[LD_OUT] = 1'b1; end
      OP_JMP: begin
        o_sel       = SEL_ZERO;
        o_ld[LD_PC] = 1'b1;
        o_pc_inc    = 1'b0;
      end
      // Jump only when no carry; otherwise behaves as a NOP.
      OP_JNC: begin
        if (!i_carry) begin
          o_sel       = SEL_ZERO;
          o_ld[LD_PC] = 1'b1;
          o_pc_inc    = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/td4_ctrl.sv
// ============================================================================
// Module : td4_ctrl
// Brief  : TD4 multi-cycle controller: IDLE/FETCH/EXEC FSM, IR and carry flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module td4_ctrl
  import td4_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              run,
  input  logic              step,
  output logic              carry,
  output logic              busy,
  td4_ctrl_if.master        bus
);

  state_e        r_state;
  logic [DW+3:0] r_ir;
  logic          r_carry;

  logic [3:0]    w_ld;
  logic [1:0]    w_sel;
  logic [DW-1:0] w_imm;
  logic          w_pc_inc;
  logic          w_exec;

  td4_decode #(.DW(DW)) u_decode (
    .i_op     (r_ir[DW+3:DW]),
    .i_imm    (r_ir[DW-1:0]),
    .i_carry  (r_carry),
    .o_ld     (w_ld),
    .o_sel    (w_sel),
    .o_imm    (w_imm),
    .o_pc_inc (w_pc_inc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_ir    <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run || step) r_state <= FETCH;
        end
        FETCH: begin
          r_ir    <= bus.instr;
          r_state <= EXEC;
        end
        EXEC: begin
          r_carry <= bus.c_alu;
          r_state <= run ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // State resets asynchronously, so the gating drops all enables at once.
  assign w_exec     = (r_state == EXEC);
  assign bus.ld     = w_exec ? w_ld     : '0;
  assign bus.sel    = w_exec ? w_sel    : '0;
  assign bus.imm    = w_exec ? w_imm    : '0;
  assign bus.pc_inc = w_exec ? w_pc_inc : 1'b0;
  assign carry      = r_carry;
  assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/td4_ctrl.md
Name: td4_ctrl

Overview:
Multi-cycle control unit for the 4-bit TD4-style CPU datapath built from dff4 registers (A, B, OUT, PC), the adder/ALU and the source mux. It latches the instruction, decodes it and drives one-hot load enables, the mux select, the immediate and the PC increment. It also owns the carry flag and supports run and single-step control.

Parameters:
DW, 4, data/immediate width; instruction width is 4+DW (opcode always 4 bits)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
run  in  1  level; 1 = free-running execution
step  in  1  single-cycle pulse; executes exactly one instruction while run=0
instr  in  4+DW  instruction from ROM at current PC: [DW+3:DW] opcode, [DW-1:0] immediate
c_alu  in  1  carry-out of the ALU adder for the current operands
ld  out  4  one-hot load enables to dff4 registers; bit0 A, bit1 B, bit2 OUT, bit3 PC
sel  out  2  ALU operand-A mux: 0 A, 1 B, 2 IN port, 3 zero
imm  out  DW  immediate to ALU operand B
pc_inc  out  1  PC register loads PC+1 this cycle
carry  out  1  carry flag
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE, IR=0, carry=0, ld=0, sel=0, imm=0, pc_inc=0, busy=0. Takes effect immediately, including mid-FETCH or mid-EXEC; no load enable may be asserted while n_rst=0.
- States: IDLE, FETCH, EXEC.
- IDLE -> FETCH when run=1 or step=1. Otherwise stay in IDLE. step is sampled only in IDLE.
- FETCH: IR <= instr; the next state is always EXEC. Outputs ld=0, pc_inc=0, sel=0, imm=0.
- EXEC: decode outputs are combinational from IR. carry <= c_alu at the end of EXEC for every opcode, including jumps and NOP. Next state is FETCH if run=1, else IDLE.
- Instruction latency: 2 cycles (FETCH + EXEC). Registers capture on the clock edge that ends EXEC.
- Decode in EXEC (opcode: sel, ld, pc_inc). imm=IR immediate unless stated:
  - 0000 ADD A,Im: sel A, ld A, pc_inc
  - 0101 ADD B,Im: sel B, ld B, pc_inc
  - 0011 MOV A,Im: sel zero, ld A, pc_inc
  - 0111 MOV B,Im: sel zero, ld B, pc_inc
  - 0001 MOV A,B: sel B, imm=0, ld A, pc_inc
  - 0100 MOV B,A: sel A, imm=0, ld B, pc_inc
  - 0010 IN A: sel IN, imm=0, ld A, pc_inc
  - 0110 IN B: sel IN, imm=0, ld B, pc_inc
  - 1001 OUT B: sel B, imm=0, ld OUT, pc_inc
  - 1011 OUT Im: sel zero, ld OUT, pc_inc
  - 1111 JMP Im: sel zero, ld PC, pc_inc=0
  - 1110 JNC Im: if carry=0 then sel zero, ld PC, pc_inc=0; else ld=0, pc_inc=1. Uses the flag value held before this EXEC.
  - All other opcodes: NOP; ld=0, pc_inc=1.
- Invariants: ld is zero or one-hot. ld[3] and pc_inc are never both 1. Outputs are only non-zero in EXEC.
- Mid-instruction run/step changes:
  - run dropping during FETCH completes the instruction, then goes to IDLE.
  - step asserted outside IDLE is ignored.
  - step=1 with run=1 behaves as run.
- Carry wrap: ADD with sum >15 gives c_alu=1 and carry=1 after EXEC. Any following non-overflowing instruction clears it.

Decomposition:
- Package td4_pkg:
  - opcode_e enum (4-bit values above)
  - state_e enum {IDLE, FETCH, EXEC}
  - sel_e enum {SEL_A, SEL_B, SEL_IN, SEL_ZERO}
  - localparams LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3
- Sub-module td4_decode: purely combinational; opcode + immediate + carry -> ld, sel, imm, pc_inc.
- td4_ctrl holds the FSM, IR and carry register, and gates decode outputs with state==EXEC.

Test Plan:
1. Reset hold: n_rst=0 with run=1 and instr=8'h35 for 10 cycles -> state IDLE, ld=0, pc_inc=0, carry=0. Release n_rst -> FETCH on the next edge.
2. MOV A,5 (8'h35), run=1 -> cycle 1 FETCH with ld=0; cycle 2 EXEC with ld=4'b0001, sel=3, imm=5, pc_inc=1; back to FETCH.
3. ADD A,Im overflow: instr=8'h0F with c_alu=1 -> EXEC ld=0001, sel=0, imm=15; carry=1 afterwards. Next JNC 3 (8'hE3) -> ld=0, pc_inc=1. Then carry=0 and JNC 3 again -> ld=4'b1000, imm=3, pc_inc=0.
4. JMP 9 (8'hF9) -> EXEC ld=4'b1000, sel=3, imm=9, pc_inc=0. Undefined opcode 8'h8A -> ld=0, pc_inc=1.
5. Single-step: run=0, one step pulse -> exactly one FETCH+EXEC, then IDLE with busy=0. A second step pulse issued during EXEC is ignored.
6. Async reset mid-EXEC: assert n_rst=0 half a cycle into EXEC of 8'h35 -> ld drops to 0 immediately with no A load; state=IDLE and carry=0.
